// File: rtl/psum_writeback_arbiter.sv
// Per-row psum FIFOs drained round-robin onto a single registered valid/ready
// BRAM write port, with sticky per-row overflow flags for dropped pushes.
module psum_writeback_arbiter #(
    parameter int ARRAY_ROWS = 3,
    parameter int PSUM_W     = 48,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int ROW_W     = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ARRAY_ROWS-1:0]               psum_valid,
    input  logic [ARRAY_ROWS-1:0][PSUM_W-1:0]   psums,
    input  logic [ARRAY_ROWS-1:0][ADDR_W-1:0]   psum_addr,
    input  logic                                wr_ready,
    output logic                                wr_en,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic [PSUM_W-1:0]                   wr_data,
    output logic [ROW_W-1:0]                    wr_row,
    output logic [ARRAY_ROWS-1:0]               overflow,
    input  logic                                clear_overflow,
    output logic                                busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + PSUM_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_ROWS - 1);

    logic [ARRAY_ROWS-1:0] nonempty;
    logic [ARRAY_ROWS-1:0] pop;
    logic [ARRAY_ROWS-1:0] push_ok;
    logic [ARRAY_ROWS-1:0] drop;
    logic [ENTRY_W-1:0]    head [ARRAY_ROWS];

    logic [ROW_W-1:0]      rr_ptr;
    logic [ROW_W-1:0]      grant_idx;
    logic [ENTRY_W-1:0]    grant_entry;
    logic                  grant_found;
    logic                  can_pop;

    // Output register is free when empty or completing this cycle.
    assign can_pop = !wr_en || wr_ready;

    // Stage 0: per-row FIFOs (push side)
    for (genvar g = 0; g < ARRAY_ROWS; g++) begin : g_row
        logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]   rd_ptr;
        logic [PTR_W-1:0]   wr_ptr;
        logic [CNT_W-1:0]   count;

        assign nonempty[g] = (count != '0);
        assign pop[g]      = can_pop && grant_found && (grant_idx == ROW_W'(g));
        assign push_ok[g]  = psum_valid[g] && ((count != FULL_CNT) || pop[g]);
        assign drop[g]     = psum_valid[g] && !push_ok[g];
        assign head[g]     = mem[rd_ptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok[g]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[g])     rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push_ok[g]) - CNT_W'(pop[g]);
            end
        end

        always_ff @(posedge clk) begin
            if (push_ok[g]) mem[wr_ptr] <= {psum_addr[g], psums[g]};
        end
    end

    // Round-robin search: rows above the pointer first, then wrap to the rest.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        for (int i = 0; i < ARRAY_ROWS; i++) begin
            if (!grant_found && nonempty[i] && (ROW_W'(i) > rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ROW_W'(i);
                grant_entry = head[i];
            end
        end
        for (int i = 0; i < ARRAY_ROWS; i++) begin
            if (!grant_found && nonempty[i] && (ROW_W'(i) <= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ROW_W'(i);
                grant_entry = head[i];
            end
        end
    end

    // Stage 1: write output register (valid/ready)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_row  <= '0;
            rr_ptr  <= LAST_ROW;
        end else if (can_pop) begin
            wr_en <= grant_found;
            if (grant_found) begin
                {wr_addr, wr_data} <= grant_entry;
                wr_row             <= grant_idx;
                rr_ptr             <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= '0;
        end else begin
            overflow <= (clear_overflow ? '0 : overflow) | drop;
        end
    end

    assign busy = (|nonempty) || wr_en;

endmodule

// File: tb/tb_psum_writeback_arbiter.sv
// Bench for psum_writeback_arbiter: directed vector table, hand-written
// fairness / async-reset sequences, and randomized traffic against a queue model.
module tb_psum_writeback_arbiter;

    localparam int ROWS  = 3;
    localparam int PW    = 48;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [ROWS-1:0]           psum_valid;
    logic [ROWS-1:0][PW-1:0]   psums;
    logic [ROWS-1:0][AW-1:0]   psum_addr;
    logic                      wr_ready;
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [PW-1:0]             wr_data;
    logic [1:0]                wr_row;
    logic [ROWS-1:0]           overflow;
    logic                      clear_overflow;
    logic                      busy;

    always #5 clk = ~clk;

    psum_writeback_arbiter #(
        .ARRAY_ROWS (ROWS),
        .PSUM_W     (PW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .psum_valid     (psum_valid),
        .psums          (psums),
        .psum_addr      (psum_addr),
        .wr_ready       (wr_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_row         (wr_row),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .busy           (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic [ROWS-1:0]         valid;
        logic [ROWS-1:0][PW-1:0] d;
        logic [ROWS-1:0][AW-1:0] a;
        logic                    rdy;
        logic                    clr;
        logic                    e_en;
        logic [1:0]              e_row;
        logic [AW-1:0]           e_addr;
        logic [PW-1:0]           e_data;
        logic [ROWS-1:0]         e_ovf;
        logic                    e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] v,
                       input logic [47:0] d0, input logic [47:0] d1, input logic [47:0] d2,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                       input logic rdy, input logic clr,
                       input logic en, input logic [1:0] row,
                       input logic [31:0] ea, input logic [47:0] ed,
                       input logic [2:0] ovf, input logic bsy);
        vec_t t;
        t.valid = v;
        t.d[0] = d0; t.d[1] = d1; t.d[2] = d2;
        t.a[0] = a0; t.a[1] = a1; t.a[2] = a2;
        t.rdy = rdy; t.clr = clr;
        t.e_en = en; t.e_row = row; t.e_addr = ea; t.e_data = ed;
        t.e_ovf = ovf; t.e_busy = bsy;
        vecs.push_back(t);
    endtask

    // Reference model: plain queues per row plus a one-entry output slot.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [PW-1:0] d;
    } ent_t;

    ent_t            mq [ROWS][$];
    logic            m_en;
    ent_t            m_out;
    int              m_ptr;
    int              m_row;
    logic [ROWS-1:0] m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < ROWS; i++) mq[i].delete();
        m_en  = 1'b0;
        m_out = '0;
        m_ptr = ROWS - 1;
        m_row = 0;
        m_ovf = '0;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = m_en;
        for (int i = 0; i < ROWS; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic void model_step();
        int g;
        int r;
        g = -1;
        if (!m_en || wr_ready) begin
            for (int k = 1; k <= ROWS; k++) begin
                r = (m_ptr + k) % ROWS;
                if (g < 0 && mq[r].size() > 0) g = r;
            end
            if (g >= 0) begin
                m_out = mq[g].pop_front();
                m_en  = 1'b1;
                m_row = g;
                m_ptr = g;
            end else begin
                m_en = 1'b0;
            end
        end
        if (clear_overflow) m_ovf = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (psum_valid[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({psum_addr[i], psums[i]});
                else m_ovf[i] = 1'b1;
            end
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    int fair_exp [6] = '{0, 2, 0, 2, 0, 2};

    initial begin
        int got;
        int thr;

        rst_n          = 1'b0;
        psum_valid     = '0;
        psums          = '0;
        psum_addr      = '0;
        wr_ready       = 1'b0;
        clear_overflow = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset wr_en",    128'(wr_en),    128'(0));
        check("reset wr_addr",  128'(wr_addr),  128'(0));
        check("reset wr_data",  128'(wr_data),  128'(0));
        check("reset wr_row",   128'(wr_row),   128'(0));
        check("reset overflow", 128'(overflow), 128'(0));
        check("reset busy",     128'(busy),     128'(0));
        rst_n = 1'b1;

        // simultaneous rows -> order 0,1,2 with no gaps
        add(3'b111, 48'h1000, 48'h2000, 48'h3000, 32'h200, 32'h204, 32'h208, 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h200, 48'h1000, 3'b000, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h204, 48'h2000, 3'b000, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h208, 48'h3000, 3'b000, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0);
        // single row push, two-cycle latency
        add(3'b010, 0, 48'h1234, 0, 0, 32'h40, 0, 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h40, 48'h1234, 3'b000, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0);
        // row 2 pushes six under backpressure; sixth is dropped
        add(3'b100, 0, 0, 48'hE1, 0, 0, 32'h11, 0, 0, 0, 0, 0, 0, 3'b000, 1);
        add(3'b100, 0, 0, 48'hE2, 0, 0, 32'h12, 0, 0, 1, 2, 32'h11, 48'hE1, 3'b000, 1);
        add(3'b100, 0, 0, 48'hE3, 0, 0, 32'h13, 0, 0, 1, 2, 32'h11, 48'hE1, 3'b000, 1);
        add(3'b100, 0, 0, 48'hE4, 0, 0, 32'h14, 0, 0, 1, 2, 32'h11, 48'hE1, 3'b000, 1);
        add(3'b100, 0, 0, 48'hE5, 0, 0, 32'h15, 0, 0, 1, 2, 32'h11, 48'hE1, 3'b000, 1);
        add(3'b100, 0, 0, 48'hE6, 0, 0, 32'h16, 0, 0, 1, 2, 32'h11, 48'hE1, 3'b100, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h12, 48'hE2, 3'b100, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h13, 48'hE3, 3'b100, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h14, 48'hE4, 3'b100, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h15, 48'hE5, 3'b100, 1);
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b100, 0);
        // clear with no concurrent drop
        add(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 0);

        foreach (vecs[k]) begin
            psum_valid     = vecs[k].valid;
            psums          = vecs[k].d;
            psum_addr      = vecs[k].a;
            wr_ready       = vecs[k].rdy;
            clear_overflow = vecs[k].clr;
            @(posedge clk); #1;
            check($sformatf("vec%0d en/busy/ovf", k), 128'({wr_en, busy, overflow}),
                  128'({vecs[k].e_en, vecs[k].e_busy, vecs[k].e_ovf}));
            if (vecs[k].e_en)
                check($sformatf("vec%0d row/addr/data", k), 128'({wr_row, wr_addr, wr_data}),
                      128'({vecs[k].e_row, vecs[k].e_addr, vecs[k].e_data}));
        end
        psum_valid     = '0;
        clear_overflow = 1'b0;

        // Fairness: rows 0 and 2 backlogged, row 1 idle
        wr_ready   = 1'b0;
        psum_valid = 3'b101;
        for (int c = 0; c < 4; c++) begin
            psums[0] = 48'hF00 + 48'(c);
            psums[2] = 48'hF20 + 48'(c);
            @(posedge clk); #1;
        end
        psum_valid = '0;
        wr_ready   = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (wr_en && wr_ready) begin
                check($sformatf("fair%0d row", got), 128'(wr_row), 128'(fair_exp[got]));
                got++;
            end
            @(posedge clk); #1;
        end
        check("fair transfer count", 128'(got), 128'(6));
        for (int c = 0; c < 30 && busy; c++) begin
            @(posedge clk); #1;
        end
        check("fair drained busy", 128'(busy), 128'(0));
        check("fair overflow", 128'(overflow), 128'(0));

        // Asynchronous reset while work is pending
        wr_ready   = 1'b0;
        psum_valid = 3'b111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psum_valid = '0;
        check("pre-reset wr_en", 128'(wr_en), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async reset wr_en", 128'(wr_en), 128'(0));
        check("async reset busy",  128'(busy),  128'(0));
        @(posedge clk); #1;
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("post-reset idle%0d", c), 128'({wr_en, busy}), 128'(0));
        end

        // Randomized traffic against the queue model
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            thr = ((c / 150) % 2 == 1) ? 90 : 45;
            for (int i = 0; i < ROWS; i++) begin
                psum_valid[i] = ($urandom_range(0, 99) < 35);
                psums[i]      = PW'({$urandom(), $urandom()});
                psum_addr[i]  = $urandom();
            end
            wr_ready       = ($urandom_range(0, 99) < thr);
            clear_overflow = ($urandom_range(0, 99) < 4);
            model_step();
            @(posedge clk); #1;
            check($sformatf("rand%0d en/busy/ovf", c), 128'({wr_en, busy, overflow}),
                  128'({m_en, model_busy(), m_ovf}));
            if (m_en)
                check($sformatf("rand%0d row/addr/data", c), 128'({wr_row, wr_addr, wr_data}),
                      128'({2'(m_row), m_out.a, m_out.d}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
